multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 133 +++++++++++++
 rtl/imm_aluop_dec.sv | 24 ++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit: state encodings,
// ALU-op codes, opcode constants, mux select codes and the per-state control
// word lookup used to build the registered Moore outputs.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    typedef logic [2:0] aluop_t;

    localparam aluop_t ALU_ADD   = 3'd0;
    localparam aluop_t ALU_SUB   = 3'd1;
    localparam aluop_t ALU_FUNCT = 3'd2;
    localparam aluop_t ALU_AND   = 3'd3;
    localparam aluop_t ALU_OR    = 3'd4;
    localparam aluop_t ALU_SLT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Moore part of the control outputs. irwrite and the FETCH pcwrite are
    // gated by mem_ready in the top level, so they are not part of this word.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        aluop_t     aluop;
    } ctrl_t;

    // Control word for a given state. imm_op is the ALU op to use in IEXEC.
    // Anything not assigned for a state stays 0, including unused encodings.
    function automatic ctrl_t state_ctrl(input state_t s, input aluop_t imm_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread  = 1'b1;
                c.alusrcb  = SRCB_FOUR;
                c.aluop    = ALU_ADD;
                c.pcsource = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALU_FUNCT;
            end
            S_RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_REGB;
                c.aluop       = ALU_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = imm_op;
            end
            S_IWB: begin
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_aluop_dec.sv
// imm_aluop_dec
// Maps an immediate-class opcode to the ALU operation used in IEXEC.
// Ports:
//   opcode  in  6  instruction[31:26]
//   aluop   out 3  add/and/or/slt for addi/andi/ori/slti; add otherwise
module imm_aluop_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output aluop_t     aluop
);

    always_comb begin
        aluop = ALU_ADD;
        case (opcode)
            OP_ADDI: aluop = ALU_ADD;
            OP_ANDI: aluop = ALU_AND;
            OP_ORI:  aluop = ALU_OR;
            OP_SLTI: aluop = ALU_SLT;
            default: aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, j and
// the addi/andi/ori/slti immediates).
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   opcode[5:0]          instruction[31:26], sampled in DECODE
//   mem_ready            memory completes the current access this cycle
//   pcwrite .. alusrca   1-bit datapath strobes/selects
//   alusrcb, pcsource    2-bit mux selects
//   aluop[ALUOP_W-1:0]   ALU operation code (upper bits zero)
//   illegal_op           high during a DECODE cycle holding an unsupported opcode
//   state[3:0]           current state encoding for debug
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit          ENABLE_IMM  = 1'b1,
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter int unsigned ALUOP_W     = 3      // must be at least 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic               illegal_op,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic [ALUOP_W-1:0] aluop,
    output logic [3:0]         state
);

    state_t     state_reg;
    state_t     state_next;
    logic [5:0] opcode_reg;
    ctrl_t      ctrl_reg;
    ctrl_t      ctrl_out;
    aluop_t     imm_aluop;
    logic       opcode_legal;
    logic       state_valid;
    logic       fetch_done;

    imm_aluop_dec u_imm_aluop_dec (
        .opcode (opcode),
        .aluop  (imm_aluop)
    );

    always_comb begin
        state_next   = S_FETCH;
        opcode_legal = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        state_next   = S_EXEC;
                        opcode_legal = 1'b1;
                    end
                    OP_LW, OP_SW: begin
                        state_next   = S_MEMADR;
                        opcode_legal = 1'b1;
                    end
                    OP_BEQ: begin
                        state_next   = S_BRANCH;
                        opcode_legal = 1'b1;
                    end
                    OP_J: begin
                        if (ENABLE_JUMP) begin
                            state_next   = S_JUMP;
                            opcode_legal = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                        if (ENABLE_IMM) begin
                            state_next   = S_IEXEC;
                            opcode_legal = 1'b1;
                        end
                    end
                    default: state_next = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so the latched opcode picks between them.
            S_MEMADR: state_next = (opcode_reg == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_IEXEC:  state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // The control word is loaded with the outputs of the state being entered,
    // so outputs come straight from flops. IEXEC is only entered from DECODE,
    // where the opcode input is still valid for the immediate ALU-op lookup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= S_FETCH;
            opcode_reg <= '0;
            ctrl_reg   <= state_ctrl(S_FETCH, ALU_ADD);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= state_ctrl(state_next, imm_aluop);
            if (state_reg == S_DECODE) begin
                opcode_reg <= opcode;
            end
        end
    end

    // Guard against a corrupted state register driving any strobe.
    assign state_valid = (state_reg <= S_IWB);
    assign ctrl_out    = state_valid ? ctrl_reg : '0;

    // Instruction register and PC load together when the fetch completes.
    assign fetch_done = (state_reg == S_FETCH) && mem_ready;

    assign pcwrite     = ctrl_out.pcwrite | fetch_done;
    assign irwrite     = fetch_done;
    assign pcwritecond = ctrl_out.pcwritecond;
    assign iord        = ctrl_out.iord;
    assign memread     = ctrl_out.memread;
    assign memwrite    = ctrl_out.memwrite;
    assign memtoreg    = ctrl_out.memtoreg;
    assign regdst      = ctrl_out.regdst;
    assign regwrite    = ctrl_out.regwrite;
    assign alusrca     = ctrl_out.alusrca;
    assign alusrcb     = ctrl_out.alusrcb;
    assign pcsource    = ctrl_out.pcsource;
    assign aluop       = ALUOP_W'(ctrl_out.aluop);
    assign state       = state_reg;

    // Reset drives the state to FETCH asynchronously, which clears this too.
    assign illegal_op  = (state_reg == S_DECODE) && !opcode_legal;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;

    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] aluop;
    logic [3:0] state;

    logic       n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite;
    logic       n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_illegal_op;
    logic [1:0] n_alusrcb, n_pcsource;
    logic [2:0] n_aluop;
    logic [3:0] n_state;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    multicycle_control #(.ENABLE_IMM(1'b1), .ENABLE_JUMP(1'b1), .ALUOP_W(3)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .illegal_op(illegal_op),
        .alusrcb(alusrcb), .pcsource(pcsource), .aluop(aluop), .state(state)
    );

    multicycle_control #(.ENABLE_IMM(1'b0), .ENABLE_JUMP(1'b1), .ALUOP_W(3)) dut_noimm (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(n_pcwrite), .pcwritecond(n_pcwritecond), .iord(n_iord), .memread(n_memread),
        .memwrite(n_memwrite), .irwrite(n_irwrite), .memtoreg(n_memtoreg), .regdst(n_regdst),
        .regwrite(n_regwrite), .alusrca(n_alusrca), .illegal_op(n_illegal_op),
        .alusrcb(n_alusrcb), .pcsource(n_pcsource), .aluop(n_aluop), .state(n_state)
    );

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b111111;
        repeat (2) @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL rst_state: got %0d expected 0", state); else passes++;
        checks++; if (illegal_op !== 1'b0) $display("FAIL rst_illegal: got %0b expected 0", illegal_op); else passes++;
        checks++; if (memread !== 1'b1) $display("FAIL rst_memread: got %0b expected 1", memread); else passes++;
        checks++; if (alusrcb !== 2'b01) $display("FAIL rst_alusrcb: got %0b expected 01", alusrcb); else passes++;
        checks++; if (n_state !== 4'd0) $display("FAIL rst_noimm_state: got %0d expected 0", n_state); else passes++;
        reset = 1'b0;
        @(negedge clock);
        $display("reset released, FETCH waiting on memory: state=%0d irwrite=%0b pcwrite=%0b", state, irwrite, pcwrite);
        checks++; if (state !== 4'd0) $display("FAIL fetch_hold_state: got %0d expected 0", state); else passes++;
        checks++; if (irwrite !== 1'b0) $display("FAIL fetch_hold_irwrite: got %0b expected 0", irwrite); else passes++;
        checks++; if (pcwrite !== 1'b0) $display("FAIL fetch_hold_pcwrite: got %0b expected 0", pcwrite); else passes++;
        mem_ready = 1'b1;
        #1;
        checks++; if (irwrite !== 1'b1) $display("FAIL fetch_ready_irwrite: got %0b expected 1", irwrite); else passes++;
        checks++; if (pcwrite !== 1'b1) $display("FAIL fetch_ready_pcwrite: got %0b expected 1", pcwrite); else passes++;
    endtask

    task automatic test_lw;
        int exp_st[6] = '{0, 1, 2, 3, 4, 0};
        opcode = 6'b100011;
        for (int i = 0; i < 6; i++) begin
            $display("lw cycle %0d: state=%0d regwrite=%0b memtoreg=%0b", i, state, regwrite, memtoreg);
            checks++; if (state !== 4'(exp_st[i])) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_st[i]); else passes++;
            checks++; if (regwrite !== (exp_st[i] == 4)) $display("FAIL lw_regwrite[%0d]: got %0b expected %0b", i, regwrite, exp_st[i] == 4); else passes++;
            checks++; if (memtoreg !== (exp_st[i] == 4)) $display("FAIL lw_memtoreg[%0d]: got %0b expected %0b", i, memtoreg, exp_st[i] == 4); else passes++;
            if (exp_st[i] == 3) begin
                checks++; if (iord !== 1'b1) $display("FAIL lw_iord: got %0b expected 1", iord); else passes++;
            end
            if (i < 5) @(negedge clock);
        end
        checks++; if (n_state !== 4'd0) $display("FAIL lw_noimm_state: got %0d expected 0", n_state); else passes++;
    endtask

    task automatic test_sw;
        opcode = 6'b101011;
        @(negedge clock);
        @(negedge clock);
        checks++; if (state !== 4'd2) $display("FAIL sw_memadr: got %0d expected 2", state); else passes++;
        checks++; if (alusrcb !== 2'b10) $display("FAIL sw_alusrcb: got %0b expected 10", alusrcb); else passes++;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            $display("sw wait %0d: state=%0d memwrite=%0b regwrite=%0b", i, state, memwrite, regwrite);
            checks++; if (state !== 4'd5) $display("FAIL sw_state[%0d]: got %0d expected 5", i, state); else passes++;
            checks++; if (memwrite !== 1'b1) $display("FAIL sw_memwrite[%0d]: got %0b expected 1", i, memwrite); else passes++;
            checks++; if (regwrite !== 1'b0) $display("FAIL sw_regwrite[%0d]: got %0b expected 0", i, regwrite); else passes++;
            if (i == 3) mem_ready = 1'b1;
        end
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL sw_done_state: got %0d expected 0", state); else passes++;
        checks++; if (memwrite !== 1'b0) $display("FAIL sw_done_memwrite: got %0b expected 0", memwrite); else passes++;
    endtask

    task automatic test_branch;
        opcode = 6'b000100;
        @(negedge clock);
        checks++; if (pcwrite !== 1'b0) $display("FAIL beq_decode_pcwrite: got %0b expected 0", pcwrite); else passes++;
        @(negedge clock);
        $display("beq: state=%0d pcwritecond=%0b pcsource=%0b aluop=%0d", state, pcwritecond, pcsource, aluop);
        checks++; if (state !== 4'd8) $display("FAIL beq_state: got %0d expected 8", state); else passes++;
        checks++; if (pcwritecond !== 1'b1) $display("FAIL beq_pcwritecond: got %0b expected 1", pcwritecond); else passes++;
        checks++; if (pcsource !== 2'b01) $display("FAIL beq_pcsource: got %0b expected 01", pcsource); else passes++;
        checks++; if (aluop !== 3'd1) $display("FAIL beq_aluop: got %0d expected 1", aluop); else passes++;
        checks++; if (pcwrite !== 1'b0) $display("FAIL beq_pcwrite: got %0b expected 0", pcwrite); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL beq_done_state: got %0d expected 0", state); else passes++;
        checks++; if (pcwritecond !== 1'b0) $display("FAIL beq_done_pcwritecond: got %0b expected 0", pcwritecond); else passes++;
    endtask

    task automatic test_jump;
        opcode = 6'b000010;
        @(negedge clock);
        @(negedge clock);
        $display("j: state=%0d pcwrite=%0b pcsource=%0b", state, pcwrite, pcsource);
        checks++; if (state !== 4'd9) $display("FAIL j_state: got %0d expected 9", state); else passes++;
        checks++; if (pcwrite !== 1'b1) $display("FAIL j_pcwrite: got %0b expected 1", pcwrite); else passes++;
        checks++; if (pcsource !== 2'b10) $display("FAIL j_pcsource: got %0b expected 10", pcsource); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL j_done_state: got %0d expected 0", state); else passes++;
    endtask

    task automatic test_rtype;
        opcode = 6'b000000;
        @(negedge clock);
        @(negedge clock);
        $display("rtype exec: state=%0d aluop=%0d alusrca=%0b alusrcb=%0b", state, aluop, alusrca, alusrcb);
        checks++; if (state !== 4'd6) $display("FAIL r_exec_state: got %0d expected 6", state); else passes++;
        checks++; if (aluop !== 3'd2) $display("FAIL r_aluop: got %0d expected 2", aluop); else passes++;
        checks++; if (alusrca !== 1'b1) $display("FAIL r_alusrca: got %0b expected 1", alusrca); else passes++;
        checks++; if (alusrcb !== 2'b00) $display("FAIL r_alusrcb: got %0b expected 00", alusrcb); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd7) $display("FAIL r_wb_state: got %0d expected 7", state); else passes++;
        checks++; if (regwrite !== 1'b1) $display("FAIL r_regwrite: got %0b expected 1", regwrite); else passes++;
        checks++; if (regdst !== 1'b1) $display("FAIL r_regdst: got %0b expected 1", regdst); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL r_done_state: got %0d expected 0", state); else passes++;
    endtask

    task automatic test_ori;
        opcode = 6'b001101;
        @(negedge clock);
        $display("ori decode: illegal_op=%0b noimm_state=%0d noimm_illegal_op=%0b", illegal_op, n_state, n_illegal_op);
        checks++; if (illegal_op !== 1'b0) $display("FAIL ori_illegal: got %0b expected 0", illegal_op); else passes++;
        checks++; if (n_state !== 4'd1) $display("FAIL ori_noimm_decode: got %0d expected 1", n_state); else passes++;
        checks++; if (n_illegal_op !== 1'b1) $display("FAIL ori_noimm_illegal: got %0b expected 1", n_illegal_op); else passes++;
        @(negedge clock);
        $display("ori iexec: state=%0d aluop=%0d noimm_state=%0d", state, aluop, n_state);
        checks++; if (state !== 4'd10) $display("FAIL ori_iexec_state: got %0d expected 10", state); else passes++;
        checks++; if (aluop !== 3'd4) $display("FAIL ori_aluop: got %0d expected 4", aluop); else passes++;
        checks++; if (alusrcb !== 2'b10) $display("FAIL ori_alusrcb: got %0b expected 10", alusrcb); else passes++;
        checks++; if (n_state !== 4'd0) $display("FAIL ori_noimm_fetch: got %0d expected 0", n_state); else passes++;
        checks++; if (n_illegal_op !== 1'b0) $display("FAIL ori_noimm_pulse: got %0b expected 0", n_illegal_op); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd11) $display("FAIL ori_iwb_state: got %0d expected 11", state); else passes++;
        checks++; if (regwrite !== 1'b1) $display("FAIL ori_regwrite: got %0b expected 1", regwrite); else passes++;
        checks++; if (regdst !== 1'b0) $display("FAIL ori_regdst: got %0b expected 0", regdst); else passes++;
        checks++; if (n_regwrite !== 1'b0) $display("FAIL ori_noimm_regwrite: got %0b expected 0", n_regwrite); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL ori_done_state: got %0d expected 0", state); else passes++;
    endtask

    task automatic test_illegal;
        opcode = 6'b111111;
        @(negedge clock);
        $display("illegal decode: state=%0d illegal_op=%0b", state, illegal_op);
        checks++; if (state !== 4'd1) $display("FAIL ill_state: got %0d expected 1", state); else passes++;
        checks++; if (illegal_op !== 1'b1) $display("FAIL ill_pulse: got %0b expected 1", illegal_op); else passes++;
        checks++; if ({regwrite, memwrite, pcwrite, pcwritecond, irwrite} !== 5'b0)
            $display("FAIL ill_strobes: got %05b expected 00000", {regwrite, memwrite, pcwrite, pcwritecond, irwrite}); else passes++;
        @(negedge clock);
        checks++; if (state !== 4'd0) $display("FAIL ill_fetch_state: got %0d expected 0", state); else passes++;
        checks++; if (illegal_op !== 1'b0) $display("FAIL ill_pulse_end: got %0b expected 0", illegal_op); else passes++;
    endtask

    task automatic test_reset_midop;
        opcode = 6'b100011;
        @(negedge clock);
        @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        checks++; if (state !== 4'd3) $display("FAIL rmid_memrd_state: got %0d expected 3", state); else passes++;
        checks++; if (iord !== 1'b1) $display("FAIL rmid_memrd_iord: got %0b expected 1", iord); else passes++;
        #2 reset = 1'b1;
        #1;
        $display("reset in MEMRD: state=%0d iord=%0b regwrite=%0b", state, iord, regwrite);
        checks++; if (state !== 4'd0) $display("FAIL rmid_async_state: got %0d expected 0", state); else passes++;
        checks++; if (iord !== 1'b0) $display("FAIL rmid_async_iord: got %0b expected 0", iord); else passes++;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (state !== 4'd0) $display("FAIL rmid_hold_state[%0d]: got %0d expected 0", i, state); else passes++;
            checks++; if ({regwrite, memwrite} !== 2'b00) $display("FAIL rmid_no_write[%0d]: got %02b expected 00", i, {regwrite, memwrite}); else passes++;
        end
        checks++; if (n_state !== 4'd0) $display("FAIL rmid_noimm_state: got %0d expected 0", n_state); else passes++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_rtype();
        test_ori();
        test_illegal();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
